psram_qpi_ctrl: RTL and testbench

- Controller for two QPI PSRAM chips sharing one chip-select and clock.
- Bank 0 uses io_psram_data0..3; bank 1 uses io_psram_data4..7.
- After reset it waits a power-up delay, then switches both chips to QPI mode.
- It then serves single-byte read/write requests from the system bus (24-bit address, 8-bit data).

---
 rtl/psram_qpi_pkg.sv | 25 ++
 rtl/psram_nibble_io.sv | 31 +++
 rtl/psram_qpi_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_psram_qpi_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psram_qpi_pkg.sv
// Shared types and command codes for the dual-chip QPI PSRAM controller.
package psram_qpi_pkg;

  typedef enum logic [3:0] {
    ResetState,
    sendQPIEnable,
    stateIdle,
    sendQPIWriteCmd,
    sendQPIReadCmd,
    sendQPIAddress,
    sendData,
    waitCycles,
    readData
  } state_e;

  localparam logic [7:0] CMD_QPI_ENABLE = 8'h35;
  localparam logic [7:0] CMD_WRITE      = 8'h38;
  localparam logic [7:0] CMD_READ       = 8'hEB;

  // Address nibble idx 0 is bits [23:20], idx 5 is bits [3:0].
  function automatic logic [3:0] addr_nibble(input logic [23:0] addr, input logic [2:0] idx);
    return 4'(addr >> (5'd20 - {idx, 2'b00}));
  endfunction

endpackage

// File: rtl/psram_nibble_io.sv
// Tri-state pads for the two PSRAM nibble buses: per-line output enables on each
// bank and a read-back mux that selects the active bank's nibble.
module psram_nibble_io (
  input  logic [3:0] out_nib_i,
  input  logic [3:0] oe_lo_i,
  input  logic [3:0] oe_hi_i,
  input  logic       bank_sel_i,
  output logic [3:0] in_nib_o,
  inout  wire        io_psram_data0,
  inout  wire        io_psram_data1,
  inout  wire        io_psram_data2,
  inout  wire        io_psram_data3,
  inout  wire        io_psram_data4,
  inout  wire        io_psram_data5,
  inout  wire        io_psram_data6,
  inout  wire        io_psram_data7
);

  assign io_psram_data0 = oe_lo_i[0] ? out_nib_i[0] : 1'bz;
  assign io_psram_data1 = oe_lo_i[1] ? out_nib_i[1] : 1'bz;
  assign io_psram_data2 = oe_lo_i[2] ? out_nib_i[2] : 1'bz;
  assign io_psram_data3 = oe_lo_i[3] ? out_nib_i[3] : 1'bz;
  assign io_psram_data4 = oe_hi_i[0] ? out_nib_i[0] : 1'bz;
  assign io_psram_data5 = oe_hi_i[1] ? out_nib_i[1] : 1'bz;
  assign io_psram_data6 = oe_hi_i[2] ? out_nib_i[2] : 1'bz;
  assign io_psram_data7 = oe_hi_i[3] ? out_nib_i[3] : 1'bz;

  assign in_nib_o = bank_sel_i ? {io_psram_data7, io_psram_data6, io_psram_data5, io_psram_data4}
                               : {io_psram_data3, io_psram_data2, io_psram_data1, io_psram_data0};

endmodule

// File: rtl/psram_qpi_ctrl.sv
// Single-byte read/write controller for two QPI PSRAMs sharing CS and SCLK.
// Define MEMCTRL_DUAL_BANK_EN to let i_bank steer traffic to the chip on data4..7.
module psram_qpi_ctrl
  import psram_qpi_pkg::*;
#(
  parameter int INIT_DELAY_CYCLES = 15000,
  parameter int READ_WAIT_CYCLES  = 7
) (
  input  logic        i_clkRAM,
  input  logic        reset,
  input  logic        i_cs,
  input  logic        i_write,
  input  logic [23:0] i_address,
  input  logic        i_bank,
  input  logic [7:0]  i_dataToWrite,
  output logic [7:0]  o_dataRead,
  inout  wire         io_psram_data0,
  inout  wire         io_psram_data1,
  inout  wire         io_psram_data2,
  inout  wire         io_psram_data3,
  inout  wire         io_psram_data4,
  inout  wire         io_psram_data5,
  inout  wire         io_psram_data6,
  inout  wire         io_psram_data7,
  output logic        o_psram_cs,
  output logic        o_psram_sclk,
  output logic        o_busy,
  output logic        o_dataReady
);

  localparam int DW = $clog2(INIT_DELAY_CYCLES + 2);

  state_e        state_q, state_d;
  logic [DW-1:0] delay_q, delay_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          init_q, init_d;
  logic          write_q, write_d;
  logic [23:0]   addr_q, addr_d;
  logic          bank_q, bank_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [3:0]    rd_hi_q, rd_hi_d;
  logic [7:0]    data_read_q, data_read_d;
  logic          ready_q, ready_d;

  logic          psram_cs, drive_bus, bank_sel;
  logic [3:0]    out_nib, oe_lo, oe_hi, in_nib;
  logic [7:0]    cmd;

`ifdef MEMCTRL_DUAL_BANK_EN
  assign bank_sel = bank_q;
`else
  logic unused_bank;
  assign unused_bank = bank_q;
  assign bank_sel    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    delay_d     = delay_q;
    cnt_d       = cnt_q;
    init_d      = init_q;
    write_d     = write_q;
    addr_d      = addr_q;
    bank_d      = bank_q;
    wdata_d     = wdata_q;
    rd_hi_d     = rd_hi_q;
    data_read_d = data_read_q;
    ready_d     = ready_q;
    psram_cs    = 1'b1;
    drive_bus   = 1'b0;
    out_nib     = 4'h0;
    oe_lo       = 4'h0;
    oe_hi       = 4'h0;
    cmd         = write_q ? CMD_WRITE : CMD_READ;
    case (state_q)
      ResetState: begin
        if (delay_q == '0) begin
          state_d = sendQPIEnable;
          cnt_d   = 8'd0;
        end else begin
          delay_d = delay_q - 1'b1;
        end
      end
      sendQPIEnable: begin
        // Chips still power up in SPI mode: one bit per clock on the SI pin.
        psram_cs = 1'b0;
        out_nib  = {3'b000, CMD_QPI_ENABLE[3'd7 - cnt_q[2:0]]};
        oe_lo    = 4'b0001;
`ifdef MEMCTRL_DUAL_BANK_EN
        oe_hi    = 4'b0001;
`endif
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == 8'd7) begin
          state_d = stateIdle;
          init_d  = 1'b1;
          cnt_d   = 8'd0;
        end
      end
      stateIdle: begin
        if (!i_cs && init_q) begin
          write_d = i_write;
          addr_d  = i_address;
          bank_d  = i_bank;
          wdata_d = i_dataToWrite;
          ready_d = 1'b0;
          cnt_d   = 8'd0;
          state_d = i_write ? sendQPIWriteCmd : sendQPIReadCmd;
        end
      end
      sendQPIWriteCmd, sendQPIReadCmd: begin
        psram_cs  = 1'b0;
        drive_bus = 1'b1;
        out_nib   = cnt_q[0] ? cmd[3:0] : cmd[7:4];
        cnt_d     = cnt_q + 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = sendQPIAddress;
          cnt_d   = 8'd0;
        end
      end
      sendQPIAddress: begin
        psram_cs  = 1'b0;
        drive_bus = 1'b1;
        out_nib   = addr_nibble(addr_q, cnt_q[2:0]);
        cnt_d     = cnt_q + 8'd1;
        if (cnt_q == 8'd5) begin
          state_d = write_q ? sendData : waitCycles;
          cnt_d   = 8'd0;
        end
      end
      sendData: begin
        psram_cs  = 1'b0;
        drive_bus = 1'b1;
        out_nib   = cnt_q[0] ? wdata_q[3:0] : wdata_q[7:4];
        cnt_d     = cnt_q + 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = stateIdle;
          cnt_d   = 8'd0;
        end
      end
      waitCycles: begin
        psram_cs = 1'b0;
        cnt_d    = cnt_q + 8'd1;
        if (cnt_q == 8'(READ_WAIT_CYCLES - 1)) begin
          state_d = readData;
          cnt_d   = 8'd0;
        end
      end
      readData: begin
        psram_cs = 1'b0;
        if (cnt_q == 8'd0) begin
          rd_hi_d = in_nib;
          cnt_d   = 8'd1;
        end else begin
          data_read_d = {rd_hi_q, in_nib};
          ready_d     = 1'b1;
          state_d     = stateIdle;
          cnt_d       = 8'd0;
        end
      end
      default: state_d = ResetState;
    endcase
    if (drive_bus) begin
      if (bank_sel) oe_hi = 4'hF;
      else          oe_lo = 4'hF;
    end
  end

  always_ff @(posedge i_clkRAM) begin
    if (!reset) begin
      state_q     <= ResetState;
      delay_q     <= DW'(INIT_DELAY_CYCLES);
      cnt_q       <= 8'd0;
      init_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= 24'd0;
      bank_q      <= 1'b0;
      wdata_q     <= 8'd0;
      rd_hi_q     <= 4'd0;
      data_read_q <= 8'd0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      delay_q     <= delay_d;
      cnt_q       <= cnt_d;
      init_q      <= init_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      bank_q      <= bank_d;
      wdata_q     <= wdata_d;
      rd_hi_q     <= rd_hi_d;
      data_read_q <= data_read_d;
      ready_q     <= ready_d;
    end
  end

  // SCLK is the inverted system clock so the chip samples mid-cycle.
  assign o_psram_cs   = psram_cs;
  assign o_psram_sclk = ~psram_cs & ~i_clkRAM;
  assign o_busy       = (state_q != stateIdle);
  assign o_dataReady  = ready_q;
  assign o_dataRead   = data_read_q;

  psram_nibble_io u_io (
    .out_nib_i      (out_nib),
    .oe_lo_i        (oe_lo),
    .oe_hi_i        (oe_hi),
    .bank_sel_i     (bank_sel),
    .in_nib_o       (in_nib),
    .io_psram_data0 (io_psram_data0),
    .io_psram_data1 (io_psram_data1),
    .io_psram_data2 (io_psram_data2),
    .io_psram_data3 (io_psram_data3),
    .io_psram_data4 (io_psram_data4),
    .io_psram_data5 (io_psram_data5),
    .io_psram_data6 (io_psram_data6),
    .io_psram_data7 (io_psram_data7)
  );

endmodule

// File: tb/tb_psram_qpi_ctrl.sv
// Self-checking bench for psram_qpi_ctrl; released lines are pulled up, so a floating line reads 1.
module tb_psram_qpi_ctrl;

  localparam int INIT = 300;
`ifdef MEMCTRL_DUAL_BANK_EN
  localparam bit DUAL = 1'b1;
`else
  localparam bit DUAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_cs = 1'b1;
  logic        i_write = 1'b0;
  logic [23:0] i_address = 24'd0;
  logic        i_bank = 1'b0;
  logic [7:0]  i_dataToWrite = 8'd0;
  wire  [7:0]  o_dataRead;
  wire         o_psram_cs, o_psram_sclk, o_busy, o_dataReady;
  wire         io0, io1, io2, io3, io4, io5, io6, io7;
  wire  [7:0]  bus;
  logic [7:0]  chip_oe = 8'd0;
  logic [7:0]  chip_val = 8'd0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  pullup (io0); pullup (io1); pullup (io2); pullup (io3);
  pullup (io4); pullup (io5); pullup (io6); pullup (io7);
  assign io0 = chip_oe[0] ? chip_val[0] : 1'bz;
  assign io1 = chip_oe[1] ? chip_val[1] : 1'bz;
  assign io2 = chip_oe[2] ? chip_val[2] : 1'bz;
  assign io3 = chip_oe[3] ? chip_val[3] : 1'bz;
  assign io4 = chip_oe[4] ? chip_val[4] : 1'bz;
  assign io5 = chip_oe[5] ? chip_val[5] : 1'bz;
  assign io6 = chip_oe[6] ? chip_val[6] : 1'bz;
  assign io7 = chip_oe[7] ? chip_val[7] : 1'bz;
  assign bus = {io7, io6, io5, io4, io3, io2, io1, io0};

  psram_qpi_ctrl #(.INIT_DELAY_CYCLES(INIT), .READ_WAIT_CYCLES(7)) dut (
    .i_clkRAM(clk), .reset(reset), .i_cs(i_cs), .i_write(i_write),
    .i_address(i_address), .i_bank(i_bank), .i_dataToWrite(i_dataToWrite),
    .o_dataRead(o_dataRead),
    .io_psram_data0(io0), .io_psram_data1(io1), .io_psram_data2(io2), .io_psram_data3(io3),
    .io_psram_data4(io4), .io_psram_data5(io5), .io_psram_data6(io6), .io_psram_data7(io7),
    .o_psram_cs(o_psram_cs), .o_psram_sclk(o_psram_sclk),
    .o_busy(o_busy), .o_dataReady(o_dataReady)
  );

  task automatic test_reset();
    reset = 1'b0;
    i_cs = 1'b1;
    chip_oe = 8'd0;
    repeat (20) @(negedge clk);
    n_cmp++;
    if (o_psram_sclk !== 1'b0 || o_psram_cs !== 1'b1 || o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ctrl got sclk=%b cs=%b busy=%b want sclk=0 cs=1 busy=1", o_psram_sclk, o_psram_cs, o_busy);
    end
    n_cmp++;
    if (o_dataReady !== 1'b0 || o_dataRead !== 8'h00) begin
      n_err++;
      $display("FAIL reset_data got ready=%b data=%h want ready=0 data=00", o_dataReady, o_dataRead);
    end
    n_cmp++;
    if (bus !== 8'hFF) begin
      n_err++;
      $display("FAIL reset_bus got %b want all released", bus);
    end
    $display("txn reset held 20 cycles");
  endtask

  task automatic test_init();
    int cycles;
    bit bad_idle;
    logic [7:0] cmd;
    logic [7:0] exp_bus;
    cycles = 0;
    bad_idle = 1'b0;
    cmd = 8'h35;
    reset = 1'b1;
    // Counter goes INIT..0 in INIT edges, one more edge leaves the delay state.
    do begin
      @(negedge clk);
      cycles++;
      if (o_psram_cs === 1'b1 && (o_psram_sclk !== 1'b0 || o_busy !== 1'b1)) bad_idle = 1'b1;
    end while (o_psram_cs !== 1'b0 && cycles < INIT + 50);
    n_cmp++;
    if (cycles != INIT + 1) begin
      n_err++;
      $display("FAIL init_delay got %0d cycles want %0d", cycles, INIT + 1);
    end
    n_cmp++;
    if (bad_idle) begin
      n_err++;
      $display("FAIL init_idle got sclk/busy activity during delay want sclk=0 busy=1");
    end
    for (int k = 0; k < 8; k++) begin
      exp_bus = 8'hFF;
      exp_bus[0] = cmd[7-k];
      if (DUAL) exp_bus[4] = cmd[7-k];
      n_cmp++;
      if (bus !== exp_bus || o_psram_cs !== 1'b0 || o_psram_sclk !== 1'b1) begin
        n_err++;
        $display("FAIL qpi_enable bit %0d got bus=%b cs=%b sclk=%b want bus=%b cs=0 sclk=1", k, bus, o_psram_cs, o_psram_sclk, exp_bus);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (o_psram_cs !== 1'b1 || o_busy !== 1'b0 || o_psram_sclk !== 1'b0 || bus !== 8'hFF) begin
      n_err++;
      $display("FAIL init_done got cs=%b busy=%b sclk=%b bus=%b want cs=1 busy=0 sclk=0 released", o_psram_cs, o_busy, o_psram_sclk, bus);
    end
    $display("txn init delay=%0d qpi_enable sent", cycles);
  endtask

  task automatic test_write(input logic [23:0] addr, input bit bank, input logic [7:0] data, input bit hold);
    logic [3:0] exp[$];
    logic [7:0] exp_bus;
    int eb;
    eb = (DUAL && bank) ? 1 : 0;
    exp.push_back(4'h3);
    exp.push_back(4'h8);
    for (int i = 5; i >= 0; i--) exp.push_back(addr[i*4 +: 4]);
    exp.push_back(data[7:4]);
    exp.push_back(data[3:0]);
    i_write = 1'b1; i_address = addr; i_bank = bank; i_dataToWrite = data; i_cs = 1'b0;
    @(negedge clk);
    if (!hold) i_cs = 1'b1;
    n_cmp++;
    if (o_busy !== 1'b1) begin
      n_err++;
      $display("FAIL wr_accept got busy=%b want 1", o_busy);
    end
    for (int k = 0; k < exp.size(); k++) begin
      if (hold) begin
        i_write = 1'($urandom_range(1, 0)); i_bank = 1'($urandom_range(1, 0));
        i_address = 24'($urandom); i_dataToWrite = 8'($urandom);
      end
      exp_bus = 8'hFF;
      exp_bus[eb*4 +: 4] = exp[k];
      n_cmp++;
      if (bus !== exp_bus || o_psram_cs !== 1'b0 || o_psram_sclk !== 1'b1) begin
        n_err++;
        $display("FAIL wr_cycle %0d got bus=%h cs=%b sclk=%b want bus=%h cs=0 sclk=1", k, bus, o_psram_cs, o_psram_sclk, exp_bus);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (o_psram_cs !== 1'b1 || o_busy !== 1'b0 || o_dataReady !== 1'b0 || bus !== 8'hFF) begin
      n_err++;
      $display("FAIL wr_done got cs=%b busy=%b ready=%b bus=%h want cs=1 busy=0 ready=0 bus=ff", o_psram_cs, o_busy, o_dataReady, bus);
    end
    $display("txn write bank=%0d addr=%h data=%h hold=%0d", bank, addr, data, hold);
  endtask

  task automatic test_read(input logic [23:0] addr, input bit bank, input logic [7:0] rdata, input bit hold);
    logic [3:0] exp[$];
    logic [7:0] exp_bus;
    int eb;
    eb = (DUAL && bank) ? 1 : 0;
    exp.push_back(4'hE);
    exp.push_back(4'hB);
    for (int i = 5; i >= 0; i--) exp.push_back(addr[i*4 +: 4]);
    i_write = 1'b0; i_address = addr; i_bank = bank; i_dataToWrite = 8'($urandom); i_cs = 1'b0;
    @(negedge clk);
    if (!hold) i_cs = 1'b1;
    n_cmp++;
    if (o_busy !== 1'b1 || o_dataReady !== 1'b0) begin
      n_err++;
      $display("FAIL rd_accept got busy=%b ready=%b want busy=1 ready=0", o_busy, o_dataReady);
    end
    for (int k = 0; k < 15; k++) begin
      if (hold) begin
        i_write = 1'($urandom_range(1, 0)); i_bank = 1'($urandom_range(1, 0));
        i_address = 24'($urandom);
      end
      exp_bus = 8'hFF;
      if (k < 8) exp_bus[eb*4 +: 4] = exp[k];
      n_cmp++;
      if (bus !== exp_bus || o_psram_cs !== 1'b0 || o_psram_sclk !== 1'b1) begin
        n_err++;
        $display("FAIL rd_cycle %0d got bus=%h cs=%b sclk=%b want bus=%h cs=0 sclk=1", k, bus, o_psram_cs, o_psram_sclk, exp_bus);
      end
      @(negedge clk);
    end
    chip_val = 8'h00;
    chip_val[eb*4 +: 4] = rdata[7:4];
    chip_oe = 8'h00;
    chip_oe[eb*4 +: 4] = 4'hF;
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (o_psram_cs !== 1'b0 || o_busy !== 1'b1) begin
        n_err++;
        $display("FAIL rd_capture %0d got cs=%b busy=%b want cs=0 busy=1", k, o_psram_cs, o_busy);
      end
      @(negedge clk);
      chip_val[eb*4 +: 4] = rdata[3:0];
    end
    chip_oe = 8'h00;
    #1;
    n_cmp++;
    if (o_psram_cs !== 1'b1 || o_busy !== 1'b0 || o_dataReady !== 1'b1 || bus !== 8'hFF) begin
      n_err++;
      $display("FAIL rd_done got cs=%b busy=%b ready=%b bus=%h want cs=1 busy=0 ready=1 bus=ff", o_psram_cs, o_busy, o_dataReady, bus);
    end
    n_cmp++;
    if (o_dataRead !== rdata) begin
      n_err++;
      $display("FAIL rd_data got %h want %h", o_dataRead, rdata);
    end
    $display("txn read bank=%0d addr=%h data=%h hold=%0d", bank, addr, rdata, hold);
  endtask

  task automatic test_ready_hold();
    int bad;
    logic [7:0] held;
    bad = 0;
    held = o_dataRead;
    i_cs = 1'b1;
    repeat (1200) begin
      @(negedge clk);
      if (o_dataReady !== 1'b1 || o_busy !== 1'b0 || o_psram_cs !== 1'b1 || o_dataRead !== held) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL ready_hold got %0d bad idle cycles want 0", bad);
    end
    $display("txn idle 1200 cycles data=%h", held);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 12; t++) begin
      logic [23:0] a;
      logic [7:0]  d;
      bit          b, hold;
      a = 24'($urandom);
      d = 8'($urandom);
      b = 1'($urandom_range(1, 0));
      hold = (t < 11);
      if ($urandom_range(1, 0) == 1) test_write(a, b, d, hold);
      else                           test_read(a, b, d, hold);
    end
  endtask

  task automatic test_mid_reset();
    i_write = 1'b1; i_address = 24'h123456; i_bank = 1'b0; i_dataToWrite = 8'hA5; i_cs = 1'b0;
    @(negedge clk);
    i_cs = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (o_psram_cs !== 1'b1 || bus !== 8'hFF || o_busy !== 1'b1 || o_psram_sclk !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset got cs=%b bus=%h busy=%b sclk=%b want cs=1 bus=ff busy=1 sclk=0", o_psram_cs, bus, o_busy, o_psram_sclk);
    end
    n_cmp++;
    if (o_dataReady !== 1'b0 || o_dataRead !== 8'h00) begin
      n_err++;
      $display("FAIL mid_reset_data got ready=%b data=%h want ready=0 data=00", o_dataReady, o_dataRead);
    end
    $display("txn reset during address phase");
    test_reset();
    test_init();
    test_write(24'($urandom), 1'b1, 8'($urandom), 1'b0);
    test_read(24'($urandom), 1'b0, 8'($urandom), 1'b0);
  endtask

  initial begin
    test_reset();
    test_init();
    test_write(24'h00AAAA, 1'b0, 8'hF0, 1'b0);
    test_read(24'h00AAAA, 1'b0, 8'($urandom), 1'b0);
    test_ready_hold();
    test_write(24'h00AAAA, 1'b1, 8'hF0, 1'b0);
    test_read(24'h00AAAA, 1'b1, 8'($urandom), 1'b0);
    test_read(24'($urandom), 1'b0, 8'h5C, 1'b0);
    test_back_to_back();
    test_read(24'($urandom), 1'b1, 8'h81, 1'b0);
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no completion want finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
